// File: rtl/ir_sequencer.sv
// Multi-cycle instruction sequencer: Moore stage strobes, retire and
// active-cycle counters, run-complete flag.
module ir_sequencer #(
   parameter int DataSize = 32,
   parameter int InsSize  = 64,
   parameter int CntSize  = 16
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                start,
   input  logic [CntSize-1:0]  total_ir,
   input  logic [DataSize-1:0] ir,
   input  logic                im_ready,
   input  logic                dm_ready,
   output logic                enable_im_fetch,
   output logic                enable_reg_read,
   output logic                enable_alu_execute,
   output logic                enable_dm_fetch,
   output logic                enable_dm_write,
   output logic                enable_reg_write,
   output logic                enable_bj,
   output logic [DataSize-1:0] ir_latched,
   output logic [2:0]          state,
   output logic [InsSize-1:0]  Ins_cnt,
   output logic [InsSize-1:0]  cycle_cnt,
   output logic                exe_ir_done
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      DECODE = 3'd2,
      EXEC   = 3'd3,
      MEM    = 3'd4,
      WB     = 3'd5,
      PCUPD  = 3'd6,
      DONE   = 3'd7
   } state_e;

   state_e              state_q, state_d;
   logic [DataSize-1:0] ir_q, ir_d;
   logic [InsSize-1:0]  ins_q, ins_d;
   logic [InsSize-1:0]  cyc_q, cyc_d;
   logic [InsSize-1:0]  ins_inc, tot_ext;
   logic [CntSize-1:0]  tot_q, tot_d;

   logic [5:0] opcode;
   logic [7:0] sub8;
   logic [4:0] sub5;
   logic [4:0] imm5;
   logic       is_load, is_store, is_branch, is_nop;

   assign opcode = ir_q[30:25];
   assign sub8   = ir_q[7:0];
   assign sub5   = ir_q[4:0];
   assign imm5   = ir_q[14:10];

   assign is_load   = (opcode == 6'b000010) ||
                      (opcode == 6'b011100 && sub8 == 8'b00000010);
   assign is_store  = (opcode == 6'b001010) ||
                      (opcode == 6'b011100 && sub8 == 8'b00001010);
   assign is_branch = (opcode == 6'b100110) || (opcode == 6'b100100);
   assign is_nop    = (opcode == 6'b100000) && (sub5 == 5'b01001) &&
                      (imm5 == 5'd0);

   // both counters stick at all-ones instead of wrapping
   assign ins_inc = (&ins_q) ? ins_q : ins_q + InsSize'(1);
   assign tot_ext = InsSize'(tot_q);

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      ins_d   = ins_q;
      tot_d   = tot_q;
      cyc_d   = cyc_q;
      if (state_q != IDLE && state_q != DONE && !(&cyc_q)) begin
         cyc_d = cyc_q + InsSize'(1);
      end
      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               tot_d   = total_ir;
               ins_d   = '0;
               cyc_d   = '0;
               state_d = (total_ir == '0) ? DONE : FETCH;
            end
         end
         FETCH: begin
            if (im_ready) begin
               ir_d    = ir;
               state_d = DECODE;
            end
         end
         DECODE: state_d = is_nop ? PCUPD : EXEC;
         EXEC: begin
            if (is_load || is_store) begin
               state_d = MEM;
            end else if (is_branch) begin
               state_d = PCUPD;
            end else begin
               state_d = WB;
            end
         end
         MEM: begin
            if (dm_ready) begin
               state_d = is_load ? WB : PCUPD;
            end
         end
         WB: state_d = PCUPD;
         PCUPD: begin
            ins_d   = ins_inc;
            state_d = (ins_inc >= tot_ext) ? DONE : FETCH;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
         ir_q    <= '0;
         ins_q   <= '0;
         cyc_q   <= '0;
         tot_q   <= '0;
      end else begin
         state_q <= state_d;
         ir_q    <= ir_d;
         ins_q   <= ins_d;
         cyc_q   <= cyc_d;
         tot_q   <= tot_d;
      end
   end

   assign enable_im_fetch    = (state_q == FETCH);
   assign enable_reg_read    = (state_q == DECODE);
   assign enable_alu_execute = (state_q == EXEC);
   assign enable_dm_fetch    = (state_q == MEM) && is_load;
   assign enable_dm_write    = (state_q == MEM) && is_store;
   assign enable_reg_write   = (state_q == WB);
   assign enable_bj          = (state_q == PCUPD) && is_branch;
   assign exe_ir_done        = (state_q == DONE);
   assign state              = state_q;
   assign ir_latched         = ir_q;
   assign Ins_cnt            = ins_q;
   assign cycle_cnt          = cyc_q;

endmodule

// File: tb/tb_ir_sequencer.sv
// Scoreboard bench for ir_sequencer: per-instruction and per-run
// expectations from a class/latency model, random waits and programs.
module tb_ir_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] total_ir = '0;
   logic [31:0] ir = '0;
   logic        im_ready = 1'b0;
   logic        dm_ready = 1'b0;
   logic        en_if, en_rr, en_alu, en_dmf, en_dmw, en_rw, en_bj;
   logic [31:0] ir_latched;
   logic [2:0]  state;
   logic [63:0] Ins_cnt, cycle_cnt;
   logic        exe_ir_done;

   ir_sequencer dut (
      .clock(clock), .reset(reset), .start(start),
      .total_ir(total_ir), .ir(ir),
      .im_ready(im_ready), .dm_ready(dm_ready),
      .enable_im_fetch(en_if), .enable_reg_read(en_rr),
      .enable_alu_execute(en_alu), .enable_dm_fetch(en_dmf),
      .enable_dm_write(en_dmw), .enable_reg_write(en_rw),
      .enable_bj(en_bj), .ir_latched(ir_latched), .state(state),
      .Ins_cnt(Ins_cnt), .cycle_cnt(cycle_cnt),
      .exe_ir_done(exe_ir_done)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit              is_run;
      logic [31:0]     ir;
      int              lat, n_if, n_rr, n_alu, n_dmf, n_dmw, n_rw, n_bj;
      longint unsigned ins, cyc;
   } exp_t;

   exp_t q[$];
   exp_t mr;
   int total = 0;
   int bad = 0;

   // program store: class 0 alu, 1 load, 2 store, 3 branch, 4 nop
   logic [31:0] prog_ir[64];
   int prog_fw[64], prog_mw[64], prog_cls[64];
   int n_prog = 0, drv_idx = 0, cur_fw = 0, cur_mw = 0;

   bit          mon_en = 0;
   logic [31:0] exp_last_ir = '0;
   logic [2:0]  prev_state = '0;
   logic        start_edge = 1'b0;
   int sp = 0, c_if = 0, c_rr = 0, c_alu = 0, c_dmf = 0;
   int c_dmw = 0, c_rw = 0, c_bj = 0;

   task automatic chk(input string name, input longint unsigned act,
                      input longint unsigned req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic clr_cnt();
      sp = 0; c_if = 0; c_rr = 0; c_alu = 0;
      c_dmf = 0; c_dmw = 0; c_rw = 0; c_bj = 0;
   endtask

   function automatic logic [31:0] gen(input int cls);
      logic [31:0] w;
      logic [5:0]  op;
      w = $urandom;
      case (cls)
         1: if ($urandom_range(1) == 0) w[30:25] = 6'b000010;
            else begin w[30:25] = 6'b011100; w[7:0] = 8'h02; end
         2: if ($urandom_range(1) == 0) w[30:25] = 6'b001010;
            else begin w[30:25] = 6'b011100; w[7:0] = 8'h0A; end
         3: w[30:25] = ($urandom_range(1) == 0) ? 6'b100110 : 6'b100100;
         4: begin
            w[30:25] = 6'b100000; w[4:0] = 5'b01001; w[14:10] = 5'd0;
         end
         default: begin
            case ($urandom_range(2))
               0: begin
                  w[30:25] = 6'b100000;
                  if (w[4:0] == 5'b01001 && w[14:10] == 5'd0)
                     w[14:10] = 5'd1;
               end
               1: begin
                  w[30:25] = 6'b011100;
                  if (w[7:0] == 8'h02 || w[7:0] == 8'h0A) w[7:0] = 8'h03;
               end
               default: begin
                  do op = 6'($urandom);
                  while (op == 6'h02 || op == 6'h0A || op == 6'h26 ||
                         op == 6'h24 || op == 6'h1C || op == 6'h20);
                  w[30:25] = op;
               end
            endcase
         end
      endcase
      return w;
   endfunction

   task automatic put(input int i, input int cls, input logic [31:0] w,
                      input int fw, input int mw);
      prog_ir[i]  = w;
      prog_cls[i] = cls;
      prog_fw[i]  = fw;
      prog_mw[i]  = (cls == 1 || cls == 2) ? mw : 0;
   endtask

   // reactive memory model: stalls fetch/mem by the planned wait counts
   always @(negedge clock) begin
      im_ready = 1'($urandom);
      dm_ready = 1'($urandom);
      ir       = $urandom;
      if (state == 3'd1) begin
         if (cur_fw > 0) begin
            im_ready = 1'b0;
            cur_fw--;
         end else begin
            im_ready = 1'b1;
            if (drv_idx < n_prog) begin
               ir     = prog_ir[drv_idx];
               cur_mw = prog_mw[drv_idx];
            end
            drv_idx++;
            cur_fw = (drv_idx < n_prog) ? prog_fw[drv_idx] : 0;
         end
      end else if (state == 3'd4) begin
         if (cur_mw > 0) begin
            dm_ready = 1'b0;
            cur_mw--;
         end else begin
            dm_ready = 1'b1;
         end
      end
   end

   always @(posedge clock) start_edge <= start;

   always @(negedge clock) begin
      if (mon_en && !reset) begin
         chk("done_flag", exe_ir_done, (state == 3'd7));
         if (state != 3'd0 && state != 3'd7) begin
            sp++;
            c_if += int'(en_if);   c_rr += int'(en_rr);
            c_alu += int'(en_alu); c_dmf += int'(en_dmf);
            c_dmw += int'(en_dmw); c_rw += int'(en_rw);
            c_bj += int'(en_bj);
         end
         if (state == 3'd1) chk("fetch_hold_ir", ir_latched, exp_last_ir);
         if (state == 3'd6) begin
            if (q.size() == 0 || q[0].is_run) begin
               total++; bad++;
               $display("FAIL retire actual=retire required=no_retire");
            end else begin
               mr = q.pop_front();
               chk("ir_latched", ir_latched, mr.ir);
               chk("latency", sp, mr.lat);
               chk("n_im_fetch", c_if, mr.n_if);
               chk("n_reg_read", c_rr, mr.n_rr);
               chk("n_alu", c_alu, mr.n_alu);
               chk("n_dm_fetch", c_dmf, mr.n_dmf);
               chk("n_dm_write", c_dmw, mr.n_dmw);
               chk("n_reg_write", c_rw, mr.n_rw);
               chk("n_bj", c_bj, mr.n_bj);
               chk("ins_cnt_pcupd", Ins_cnt, mr.ins);
               chk("cycle_cnt_pcupd", cycle_cnt, mr.cyc);
               exp_last_ir = mr.ir;
            end
            clr_cnt();
         end
         if (state == 3'd7 && (prev_state != 3'd7 || start_edge)) begin
            if (q.size() == 0 || !q[0].is_run) begin
               total++; bad++;
               $display("FAIL run_done actual=done required=running");
            end else begin
               mr = q.pop_front();
               chk("run_ins_cnt", Ins_cnt, mr.ins);
               chk("run_cycle_cnt", cycle_cnt, mr.cyc);
               chk("run_enables",
                   {en_if, en_rr, en_alu, en_dmf, en_dmw, en_rw, en_bj}, 0);
            end
            clr_cnt();
         end
      end
      prev_state = state;
   end

   task automatic recover();
      q.delete();
      reset = 1'b1;
      start = 1'b0;
      @(negedge clock);
      reset = 1'b0;
      exp_last_ir = '0;
      clr_cnt();
   endtask

   task automatic do_run(input int n);
      int base[5] = '{5, 6, 5, 4, 3};
      longint unsigned cum = 0;
      exp_t r;
      bit ok = 0;
      for (int i = 0; i < n; i++) begin
         int cls = prog_cls[i];
         r.is_run = 0;
         r.ir     = prog_ir[i];
         r.lat    = base[cls] + prog_fw[i] + prog_mw[i];
         r.n_if   = prog_fw[i] + 1;
         r.n_rr   = 1;
         r.n_alu  = (cls == 4) ? 0 : 1;
         r.n_dmf  = (cls == 1) ? prog_mw[i] + 1 : 0;
         r.n_dmw  = (cls == 2) ? prog_mw[i] + 1 : 0;
         r.n_rw   = (cls == 0 || cls == 1) ? 1 : 0;
         r.n_bj   = (cls == 3) ? 1 : 0;
         r.ins    = longint'(i);
         r.cyc    = cum + longint'(r.lat) - 1;
         q.push_back(r);
         cum += longint'(r.lat);
      end
      r = '{default: 0};
      r.is_run = 1;
      r.ins    = longint'(n);
      r.cyc    = cum;
      q.push_back(r);
      n_prog  = n;
      drv_idx = 0;
      cur_fw  = (n > 0) ? prog_fw[0] : 0;
      cur_mw  = 0;
      @(negedge clock);
      total_ir = 16'(n);
      start    = 1'b1;
      @(negedge clock);
      start    = 1'b0;
      total_ir = 16'($urandom);
      for (int k = 0; k < 3000 && !ok; k++) begin
         if (q.size() == 0 && state == 3'd7) begin
            ok = 1;
         end else begin
            start = (state != 3'd0 && state != 3'd7 &&
                     $urandom_range(15) == 0);
            @(negedge clock);
            start = 1'b0;
         end
      end
      if (!ok) begin
         total++; bad++;
         $display("FAIL run_timeout actual=pending%0d required=0", q.size());
         recover();
      end
      repeat ($urandom_range(3)) @(negedge clock);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_state", state, 0);
      chk("rst_ins_cnt", Ins_cnt, 0);
      chk("rst_cycle_cnt", cycle_cnt, 0);
      chk("rst_done", exe_ir_done, 0);
      chk("rst_ir_latched", ir_latched, 0);
      chk("rst_enables",
          {en_if, en_rr, en_alu, en_dmf, en_dmw, en_rw, en_bj}, 0);
      reset = 1'b0;
      mon_en = 1;

      do_run(0);
      put(0, 0, 32'h4000_0000, 0, 0);
      do_run(1);
      put(0, 1, 32'h0400_0000, 0, 3);
      put(1, 2, 32'h1400_0000, 0, 3);
      do_run(2);
      put(0, 4, 32'h4000_0009, 0, 0);
      put(1, 3, 32'h4C00_0000, 0, 0);
      do_run(2);
      put(0, 0, 32'h4000_0000, 10, 0);
      do_run(1);
      do_run(0);

      // reset in the middle of a long MEM stall, together with start
      mon_en = 0;
      put(0, 1, 32'h0400_0000, 0, 100);
      n_prog = 1; drv_idx = 0; cur_fw = 0; cur_mw = 0;
      @(negedge clock);
      total_ir = 16'd1;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      for (int k = 0; k < 50 && state != 3'd4; k++) @(negedge clock);
      chk("reach_mem", state, 4);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      start = 1'b1;
      @(negedge clock);
      chk("mid_rst_state", state, 0);
      chk("mid_rst_ins_cnt", Ins_cnt, 0);
      chk("mid_rst_cycle_cnt", cycle_cnt, 0);
      chk("mid_rst_ir", ir_latched, 0);
      chk("mid_rst_done", exe_ir_done, 0);
      chk("mid_rst_enables",
          {en_if, en_rr, en_alu, en_dmf, en_dmw, en_rw, en_bj}, 0);
      reset = 1'b0;
      start = 1'b0;
      cur_mw = 0;
      exp_last_ir = '0;
      clr_cnt();
      mon_en = 1;
      put(0, 0, gen(0), 1, 0);
      do_run(1);

      for (int r = 0; r < 25; r++) begin
         int n = (r % 8 == 7) ? 0 : int'($urandom_range(8, 1));
         for (int i = 0; i < n; i++) begin
            int cls = int'($urandom_range(4));
            int fw = ($urandom_range(9) == 0) ? 10 :
                     int'($urandom_range(2));
            put(i, cls, gen(cls), fw, int'($urandom_range(3)));
         end
         do_run(n);
      end

      repeat (2) @(negedge clock);
      if (q.size() != 0) begin
         total++; bad++;
         $display("FAIL leftover actual=%0d required=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ir_sequencer.md
IR_SEQUENCER -- requirements
Module: ir_sequencer

Interface
REQ-001 Parameter DataSize, default 32: instruction width in bits.
REQ-002 Parameter InsSize, default 64: width of Ins_cnt and cycle_cnt.
REQ-003 Parameter CntSize, default 16: width of total_ir.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port start, input, 1: one-cycle pulse that begins a program run; honoured only in IDLE or DONE.
REQ-007 Port total_ir, input, CntSize: number of instructions to execute in the run.
REQ-008 Port ir, input, DataSize: instruction word returned by IM.
REQ-009 Port im_ready, input, 1: IM data valid this cycle.
REQ-010 Port dm_ready, input, 1: DM access completes this cycle.
REQ-011 Ports enable_im_fetch, enable_reg_read, enable_alu_execute, enable_dm_fetch, enable_dm_write, enable_reg_write and enable_bj: each an output, 1 bit; the per-stage strobes.
REQ-012 Port ir_latched, output, DataSize: the instruction currently executing.
REQ-013 Port state, output, 3: the current FSM state encoding.
REQ-014 Port Ins_cnt, output, InsSize: the count of retired instructions.
REQ-015 Port cycle_cnt, output, InsSize: the count of active cycles.
REQ-016 Port exe_ir_done, output, 1: the run-complete flag.

Function
REQ-017 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, PCUPD=6, DONE=7.
REQ-018 Enables SHALL be Moore outputs, each asserted only in its state:
- enable_im_fetch in FETCH.
- enable_reg_read in DECODE.
- enable_alu_execute in EXEC.
- enable_dm_fetch in MEM for loads.
- enable_dm_write in MEM for stores.
- enable_reg_write in WB.
- enable_bj in PCUPD for branches.
REQ-019 IDLE SHALL go to FETCH on start when total_ir!=0, and to DONE on start when total_ir==0.
REQ-020 FETCH SHALL hold while im_ready=0; on im_ready=1, ir is latched into ir_latched and the FSM goes to DECODE.
REQ-021 Decode class SHALL be taken from ir_latched, with opcode=[30:25], sub8=[7:0], sub5=[4:0], imm5=[14:10]:
- load: opcode 000010, or opcode 011100 with sub8 00000010.
- store: opcode 001010, or opcode 011100 with sub8 00001010.
- branch: opcode 100110 or 100100.
- nop: opcode 100000, sub5 01001, imm5 0.
- alu: everything else.
REQ-022 DECODE SHALL go to PCUPD for nop and to EXEC otherwise.
REQ-023 EXEC SHALL go to MEM for load/store, to PCUPD for branch, and to WB for alu.
REQ-024 MEM SHALL hold while dm_ready=0; on dm_ready=1 it goes to WB for a load and to PCUPD for a store.
REQ-025 WB SHALL always go to PCUPD.
REQ-026 In PCUPD, Ins_cnt SHALL increment by 1; if the new value >= total_ir the FSM goes to DONE, otherwise to FETCH.
REQ-027 Zero-wait-state latency in cycles, FETCH to PCUPD inclusive, SHALL be: nop 3, branch 4, store 5, alu 5, load 6.
REQ-028 exe_ir_done SHALL be 1 exactly while in DONE; DONE holds until start or reset.
REQ-029 Start in DONE SHALL clear Ins_cnt, cycle_cnt and exe_ir_done, then go to FETCH (or stay in DONE if total_ir==0).
REQ-030 cycle_cnt SHALL increment every cycle the state is neither IDLE nor DONE, and saturate at all-ones.
REQ-031 Ins_cnt SHALL saturate at all-ones.
REQ-032 total_ir SHALL be sampled at start and held internally; later changes are ignored.
REQ-033 Start asserted outside IDLE/DONE SHALL be ignored.

Reset
REQ-034 Reset SHALL force state IDLE, clear all enables, and set ir_latched=0, Ins_cnt=0, cycle_cnt=0 and exe_ir_done=0 on the next edge, in any state including mid-MEM or mid-FETCH wait.
REQ-035 Reset SHALL take priority over start and over both ready inputs.

Verification
REQ-036 total_ir=1, ir=ADD (0x40000000), both readies tied 1, start -> FETCH, DECODE, EXEC, WB, PCUPD, DONE; Ins_cnt=1; cycle_cnt=5.
REQ-037 total_ir=2, program LWI then SWI, dm_ready low for 3 MEM cycles on each -> enable_dm_fetch high 4 cycles, then enable_dm_write high 4 cycles; cycle_cnt=6+5+6=17.
REQ-038 NOP (0x40000009) then BEQ (0x4C000000), total_ir=2 -> the NOP skips EXEC/WB; enable_bj pulses once in the BEQ's PCUPD; cycle_cnt=7.
REQ-039 im_ready held 0 for 10 cycles in FETCH -> state stays 1; ir_latched unchanged; cycle_cnt advances by 10.
REQ-040 Reset asserted during a MEM wait -> next cycle state=0, all outputs 0; a following start restarts with Ins_cnt counting from 0.
REQ-041 start with total_ir=0 -> DONE the next cycle, exe_ir_done=1, Ins_cnt=0; a second start while in DONE with total_ir=1 runs one instruction.
